// File: rtl/dadda_seq_pkg.sv
// Shared types and step tables for the sequential Dadda 15:4 multiplier controller.
// Optional zero-step skipping is enabled by defining DADDA_SEQ_ZERO_SKIP_EN.
package dadda_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [1:0] step_t;

  // Bit s set: step s takes the high half of that operand (steps LL, HL, LH, HH).
  localparam logic [3:0] STEP_A_HI = 4'b1010;
  localparam logic [3:0] STEP_B_HI = 4'b1100;

  // Per-step left shift in units of H, two bits per step, step 0 in the LSBs.
  localparam logic [7:0] STEP_SHIFT = 8'b10_01_01_00;

  function automatic logic [1:0] step_shift(input step_t s);
    return STEP_SHIFT[{s, 1'b0} +: 2];
  endfunction

  // Lowest enabled step at or above 'from'; 3'd4 means no step remains.
  function automatic logic [2:0] next_run(input logic [3:0] run, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (run[i] && (3'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

  // Step s runs only when both operand halves it multiplies are non-zero.
  function automatic logic [3:0] run_mask(input logic a_lo_nz, input logic a_hi_nz,
                                          input logic b_lo_nz, input logic b_hi_nz);
    return {a_hi_nz & b_hi_nz, a_lo_nz & b_hi_nz, a_hi_nz & b_lo_nz, a_lo_nz & b_lo_nz};
  endfunction

endpackage

// File: rtl/dadda16x16_15_4.sv
// 16x16 unsigned product; behavioural stand-in with the ports of the existing 15:4-counter Dadda array.
module dadda16x16_15_4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = 32'(a) * 32'(b);
endmodule

// File: rtl/dadda32x32_15_4.sv
// 32x32 unsigned product; behavioural stand-in with the ports of the existing 15:4-counter Dadda array.
module dadda32x32_15_4 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  assign p = 64'(a) * 64'(b);
endmodule

// File: rtl/dadda64x64_15_4.sv
// 64x64 unsigned product; behavioural stand-in with the ports of the existing 15:4-counter Dadda array.
module dadda64x64_15_4 (
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [127:0] p
);
  assign p = 128'(a) * 128'(b);
endmodule

// File: rtl/dadda8x8_15_4.sv
// 8x8 unsigned product; behavioural stand-in with the ports of the existing 15:4-counter Dadda array.
module dadda8x8_15_4 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

// File: rtl/dadda_seq_mult_15_4.sv
// WIDTHxWIDTH unsigned multiplier time-sharing one H x H Dadda array over four partial-product steps.
// Define DADDA_SEQ_ZERO_SKIP_EN to skip steps whose sub-product is known to be zero.
module dadda_seq_mult_15_4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);
  import dadda_seq_pkg::*;

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;

  state_e           state_q, state_d;
  step_t            step_q, step_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       run_in;
  logic [2:0]       nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    acc_q;
  logic             out_valid_q;
  logic             accept;

  logic [H-1:0]     op_a, op_b;
  logic [WIDTH-1:0] sub_prod;
  logic [PW-1:0]    addend;

`ifdef DADDA_SEQ_ZERO_SKIP_EN
  assign run_in = run_mask(|in_a[H-1:0], |in_a[WIDTH-1:H], |in_b[H-1:0], |in_b[WIDTH-1:H]);
`else
  assign run_in = 4'hF;
`endif

  assign accept    = (state_q == ST_IDLE) && in_valid;
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_prod  = acc_q;

  // Next-state: enter/advance to the next enabled step, or finish when none remains.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    run_d   = run_q;
    nxt     = 3'd4;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          run_d = run_in;
          nxt   = next_run(run_in, 3'd0);
          if (nxt[2]) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
            step_d  = nxt[1:0];
          end
        end
      end
      ST_CALC: begin
        nxt = next_run(run_q, {1'b0, step_q} + 3'd1);
        if (nxt[2]) begin
          state_d = ST_DONE;
        end else begin
          step_d = nxt[1:0];
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      run_q   <= run_d;
    end
  end

  assign op_a = STEP_A_HI[step_q] ? a_q[WIDTH-1:H] : a_q[H-1:0];
  assign op_b = STEP_B_HI[step_q] ? b_q[WIDTH-1:H] : b_q[H-1:0];

  // Align the sub-product to its weight within the full-width accumulator.
  always_comb begin
    addend = '0;
    case (step_shift(step_q))
      2'd0:    addend = PW'(sub_prod);
      2'd1:    addend = PW'(sub_prod) << H;
      default: addend = PW'(sub_prod) << WIDTH;
    endcase
  end

  generate
    if (WIDTH == 16) begin : g_mul
      dadda8x8_15_4 u_mul (.a(op_a), .b(op_b), .p(sub_prod));
    end else if (WIDTH == 32) begin : g_mul
      dadda16x16_15_4 u_mul (.a(op_a), .b(op_b), .p(sub_prod));
    end else if (WIDTH == 64) begin : g_mul
      dadda32x32_15_4 u_mul (.a(op_a), .b(op_b), .p(sub_prod));
    end else if (WIDTH == 128) begin : g_mul
      dadda64x64_15_4 u_mul (.a(op_a), .b(op_b), .p(sub_prod));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        acc_q <= '0;
      end else if (state_q == ST_CALC) begin
        acc_q <= acc_q + addend;
      end
      out_valid_q <= (state_d == ST_DONE);
    end
  end

endmodule
